// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and default constants for the pipeline stall
//               controller and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Memory-wait sequencer states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // Default consecutive unanswered wait cycles before the SRAM is declared hung
    localparam int c_DEFAULT_TIMEOUT_CYCLES = 64;

    // Default performance counter width
    localparam int c_DEFAULT_CNT_WIDTH = 16;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping, with a
//               synchronous clear that takes precedence over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: clear wins, otherwise step unless already saturated
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        value_q <= value_d;
    end

    assign value_o = value_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Merges data-hazard, taken-branch and SRAM-wait conditions into
//               freeze/flush strobes for a 5-stage pipeline, tracks long memory
//               waits with a timeout, and keeps saturating stall/flush counts.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = c_DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hazard_detected_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_req_i,
    input  logic                 sram_ready_i,
    output logic                 freeze_pc_o,
    output logic                 freeze_if_id_o,
    output logic                 flush_if_id_o,
    output logic                 flush_id_exe_o,
    output logic                 freeze_all_o,
    output logic                 busy_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    // Wide enough to hold TIMEOUT_CYCLES-1 for any legal TIMEOUT_CYCLES
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    logic w_flush_inc;
    logic w_stall_inc;

    // Next-state and Mealy control outputs; reset masks every strobe
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        freeze_pc_o    = 1'b0;
        freeze_if_id_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_exe_o = 1'b0;
        freeze_all_o   = 1'b0;
        error_o        = 1'b0;
        busy_o         = (state_q != ST_RUN);
        w_flush_inc    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A zero-wait access (req with ready) falls through to branch/hazard
                if (mem_req_i && !sram_ready_i) begin
                    freeze_all_o = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    wait_d       = WAIT_W'(1);
                end else if (branch_taken_i) begin
                    flush_if_id_o  = 1'b1;
                    flush_id_exe_o = 1'b1;
                    w_flush_inc    = 1'b1;
                end else if (hazard_detected_i) begin
                    freeze_pc_o    = 1'b1;
                    freeze_if_id_o = 1'b1;
                    flush_id_exe_o = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // Branch/hazard are ignored here; the frozen EXE op re-presents them
                if (sram_ready_i) begin
                    state_d = ST_RUN;
                end else begin
                    freeze_all_o = 1'b1;
                    if (wait_q == c_WAIT_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end

            ST_ERROR: begin
                freeze_all_o = 1'b1;
                error_o      = 1'b1;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            freeze_pc_o    = 1'b0;
            freeze_if_id_o = 1'b0;
            flush_if_id_o  = 1'b0;
            flush_id_exe_o = 1'b0;
            freeze_all_o   = 1'b0;
            error_o        = 1'b0;
            busy_o         = 1'b0;
            w_flush_inc    = 1'b0;
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign w_stall_inc = freeze_pc_o | freeze_all_o;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (w_stall_inc),
        .value_o (stall_count_o)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (w_flush_inc),
        .value_o (flush_count_o)
    );

endmodule : pipeline_stall_controller
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Directed bench for the stall controller. Two instances share
//               stimulus: one with default parameters, one with a short
//               timeout and 4-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst;
    logic hazard, branch, mem_req, sram_ready;

    // dut: default parameters
    logic        a_fpc, a_fifid, a_flifid, a_flidexe, a_fall, a_busy, a_err;
    logic [15:0] a_stall, a_flush;
    // dut_s: TIMEOUT_CYCLES=4, CNT_WIDTH=4
    logic        b_fpc, b_fifid, b_flifid, b_flidexe, b_fall, b_busy, b_err;
    logic [3:0]  b_stall, b_flush;

    // {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_all, busy, error}
    logic [6:0] a_outs, b_outs;
    assign a_outs = {a_fpc, a_fifid, a_flifid, a_flidexe, a_fall, a_busy, a_err};
    assign b_outs = {b_fpc, b_fifid, b_flifid, b_flidexe, b_fall, b_busy, b_err};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller dut (
        .clk               (clk),
        .rst               (rst),
        .hazard_detected_i (hazard),
        .branch_taken_i    (branch),
        .mem_req_i         (mem_req),
        .sram_ready_i      (sram_ready),
        .freeze_pc_o       (a_fpc),
        .freeze_if_id_o    (a_fifid),
        .flush_if_id_o     (a_flifid),
        .flush_id_exe_o    (a_flidexe),
        .freeze_all_o      (a_fall),
        .busy_o            (a_busy),
        .error_o           (a_err),
        .stall_count_o     (a_stall),
        .flush_count_o     (a_flush)
    );

    pipeline_stall_controller #(
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (4)
    ) dut_s (
        .clk               (clk),
        .rst               (rst),
        .hazard_detected_i (hazard),
        .branch_taken_i    (branch),
        .mem_req_i         (mem_req),
        .sram_ready_i      (sram_ready),
        .freeze_pc_o       (b_fpc),
        .freeze_if_id_o    (b_fifid),
        .flush_if_id_o     (b_flifid),
        .flush_id_exe_o    (b_flidexe),
        .freeze_all_o      (b_fall),
        .busy_o            (b_busy),
        .error_o           (b_err),
        .stall_count_o     (b_stall),
        .flush_count_o     (b_flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1ns later
    task automatic drive(input logic rs, input logic h, input logic b,
                         input logic m, input logic r);
        @(negedge clk);
        rst = rs; hazard = h; branch = b; mem_req = m; sram_ready = r;
        #1;
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; branch = 1'b0; mem_req = 1'b0; sram_ready = 1'b0;

        // Reset masks outputs even with every stall source active
        drive(1, 1, 1, 1, 0);
        check_eq("rst_outs_a", a_outs, 7'b0000000);
        check_eq("rst_outs_b", b_outs, 7'b0000000);
        drive(0, 0, 0, 0, 0);
        check_eq("idle_outs", a_outs, 7'b0000000);
        check_eq("idle_stall", a_stall, 0);
        check_eq("idle_flush", a_flush, 0);

        // Hazard for two cycles
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0);
            check_eq("hazard_outs", a_outs, 7'b1101000);
        end
        // Branch beats hazard
        drive(0, 1, 1, 0, 0);
        check_eq("branch_outs", a_outs, 7'b0011000);
        check_eq("hazard_stall", a_stall, 2);
        drive(0, 0, 0, 0, 0);
        check_eq("branch_flush", a_flush, 1);
        check_eq("branch_stall", a_stall, 2);

        // Zero-wait access continues to branch rule
        drive(0, 0, 1, 1, 1);
        check_eq("zw_branch_outs", a_outs, 7'b0011000);

        // Three wait cycles, ready on the 4th (also the timeout-boundary cycle for dut_s)
        drive(0, 0, 0, 1, 0);
        check_eq("mw1_outs", a_outs, 7'b0000100);
        drive(0, 1, 1, 1, 0);
        check_eq("mw2_outs", a_outs, 7'b0000110);
        drive(0, 1, 1, 1, 0);
        check_eq("mw3_outs", a_outs, 7'b0000110);
        drive(0, 0, 0, 1, 1);
        check_eq("mw4_outs_a", a_outs, 7'b0000010);
        check_eq("mw4_outs_b", b_outs, 7'b0000010);
        drive(0, 0, 0, 0, 0);
        check_eq("mw5_outs_a", a_outs, 7'b0000000);
        check_eq("mw5_outs_b", b_outs, 7'b0000000);
        check_eq("mw_stall", a_stall, 5);
        check_eq("mw_flush", a_flush, 2);

        // Hazard held 20 cycles: 16-bit counter keeps going, 4-bit saturates
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_eq("sat_stall_a", a_stall, 25);
        check_eq("sat_stall_b", b_stall, 15);
        drive(0, 0, 0, 0, 0);
        check_eq("sat_hold_b", b_stall, 15);

        // Timeout on dut_s (TIMEOUT_CYCLES=4) while dut keeps waiting
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check_eq("to_err_b", b_outs, 7'b0000111);
        check_eq("to_wait_a", a_outs, 7'b0000110);
        drive(0, 1, 1, 1, 1);
        check_eq("to_sticky_b", b_outs, 7'b0000111);
        check_eq("to_release_a", a_outs, 7'b0000010);
        drive(0, 0, 0, 0, 0);
        check_eq("to_sticky2_b", b_outs, 7'b0000111);
        check_eq("to_stall_a", a_stall, 30);
        drive(1, 0, 0, 0, 0);
        check_eq("to_rst_b", b_outs, 7'b0000000);
        drive(0, 0, 0, 0, 0);
        check_eq("post_rst_b", b_outs, 7'b0000000);
        check_eq("post_rst_stall_b", b_stall, 0);
        check_eq("post_rst_flush_b", b_flush, 0);
        check_eq("post_rst_stall_a", a_stall, 0);

        // Reset in the middle of a memory wait
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        check_eq("mid_wait_a", a_outs, 7'b0000110);
        drive(1, 1, 1, 1, 0);
        check_eq("mid_rst_a", a_outs, 7'b0000000);
        drive(0, 0, 0, 0, 0);
        check_eq("mid_after_a", a_outs, 7'b0000000);
        check_eq("mid_after_stall", a_stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipeline_stall_controller
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage pipeline's freeze and flush controls.
- Merges three stall sources into per-register control strobes: the data-hazard flag from the hazard unit, the taken-branch flag from EXE, and the SRAM wait from MEM.
- Tracks multi-cycle memory waits with an FSM and flags a hung SRAM after a timeout.
- Provides saturating stall and flush performance counters.

Parameters:
- TIMEOUT_CYCLES, 64, number of consecutive MEM_WAIT cycles without sram_ready that forces the ERROR state. Legal range is 2 or more.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock; every register updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- hazard_detected  input  1  RAW hazard flag from the hazard detection unit.
- branch_taken  input  1  branch resolved taken in EXE this cycle.
- mem_req  input  1  the instruction in MEM performs a load or store this cycle.
- sram_ready  input  1  SRAM access completes this cycle.
- freeze_pc  output  1  hold the PC.
- freeze_if_id  output  1  hold the IF/ID register.
- flush_if_id  output  1  clear IF/ID to a NOP.
- flush_id_exe  output  1  load a bubble (WB/MEM enables cleared) into ID/EXE.
- freeze_all  output  1  hold the PC and every pipeline register.
- busy  output  1  FSM is not in RUN.
- error  output  1  sticky SRAM timeout flag.
- stall_count  output  CNT_WIDTH  cycles with freeze_pc or freeze_all asserted.
- flush_count  output  CNT_WIDTH  number of branch flushes performed.

Behaviour:
- Reset: rst is sampled on the clock edge.
  - Effects: state becomes RUN, the wait counter, stall_count, flush_count and error clear to 0.
  - While rst=1, every control output is forced to 0, regardless of inputs.
- States: RUN, MEM_WAIT, ERROR (2-bit encoding).
- Control outputs are combinational from the current state and the inputs (Mealy). All bookkeeping is registered.
- RUN, evaluated in strict priority order:
  1. mem_req=1 and sram_ready=0: freeze_all=1; next state MEM_WAIT; wait counter loads 1.
  2. Else branch_taken=1: flush_if_id=1 and flush_id_exe=1, no freeze; flush_count increments.
  3. Else hazard_detected=1: freeze_pc=1, freeze_if_id=1, flush_id_exe=1.
  4. Else all outputs are 0.
  - mem_req=1 with sram_ready=1 in the same cycle is a zero-wait access: no freeze, and evaluation continues with the branch and hazard rules.
- MEM_WAIT:
  - freeze_all=1 while sram_ready=0.
  - On sram_ready=1: freeze_all=0 in that cycle (the pipeline advances), next state RUN.
  - branch_taken and hazard_detected are ignored while frozen. The frozen EXE instruction re-presents its branch after the release, so the branch is serviced then.
  - Wait counter increments each cycle sram_ready=0.
  - When the counter equals TIMEOUT_CYCLES-1 and sram_ready=0: next state ERROR.
  - If sram_ready=1 on that same cycle, the access completes normally and the FSM returns to RUN.
- ERROR: freeze_all=1 and error=1 permanently. Only rst exits ERROR.
- busy = (state != RUN).
- stall_count: +1 on every cycle where freeze_pc or freeze_all is 1 (this includes ERROR cycles).
- Both counters saturate at all-ones and never wrap.
- Freeze and flush for the same pipeline register are never asserted in the same cycle; the exception is the hazard case, where freeze_if_id and flush_id_exe act on different registers.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum: ST_RUN=0, ST_MEM_WAIT=1, ST_ERROR=2;
  - the default TIMEOUT_CYCLES and CNT_WIDTH constants.
- One natural sub-module, sat_counter (parameter WIDTH; inputs inc and clr; output value). Instantiate it twice, once per performance counter.

Test Plan:
- hazard_detected=1 for 2 cycles in RUN, no other inputs -> freeze_pc=freeze_if_id=flush_id_exe=1 on both cycles; stall_count=2; busy=0.
- branch_taken=1 and hazard_detected=1 in the same cycle -> flush_if_id=flush_id_exe=1, freeze_pc=0; flush_count=1, stall_count=0.
- mem_req=1 with sram_ready low for 3 cycles, then high on the 4th -> freeze_all=1 for cycles 1-3 and 0 on cycle 4; busy=1 for cycles 2-4; stall_count=3; FSM in RUN on cycle 5.
- TIMEOUT_CYCLES=4, mem_req=1, sram_ready held 0 -> ERROR entered after cycle 4; error=1 and freeze_all=1 persist when sram_ready later rises; rst for one cycle -> error=0, state RUN, counters 0.
- CNT_WIDTH=4, hazard_detected held for 20 cycles -> stall_count stops at 15 and does not wrap.
- rst asserted mid-MEM_WAIT -> all outputs 0 in the rst cycle; the next cycle with mem_req=0 shows busy=0, freeze_all=0, stall_count=0.
